// File: rtl/gray_counter.sv
// gray_counter: registered up/down Gray-code counter with load, terminal count, wrap and step pulses
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic             wrap,
  output logic             step
);
  logic [WIDTH-1:0] bin_q, bin_d, gray_q;
  logic             wrap_q, wrap_d, step_q, step_d, at_end;
  always_comb begin
    at_end = up_dn ? &bin_q : ~|bin_q;
    step_d = !load && en;
    wrap_d = step_d && at_end;
    bin_d  = load ? load_bin : en ? (up_dn ? bin_q + 1'b1 : bin_q - 1'b1) : bin_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= bin_d ^ (bin_d >> 1);
      wrap_q <= wrap_d;
      step_q <= step_d;
    end
  end
  assign gray = gray_q;
  assign tc   = at_end;
  assign wrap = wrap_q;
  assign step = step_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed and random checks of gray_counter against an arithmetic count model
module tb_gray_counter;
  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] load_bin;
  logic [3:0] gray;
  logic       tc, wrap, step;
  int         total = 0;
  int         bad = 0;
  int         m_c = 0;
  bit         m_s = 0;
  bit         m_w = 0;
  logic [3:0] prev_gray;
  logic [3:0] up_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  gray_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .gray(gray), .tc(tc), .wrap(wrap), .step(step)
  );

  always #5 clk = ~clk;

  function automatic int to_gray(input int v);
    return v ^ (v / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tc(input string tag);
    chk(tag, {31'd0, tc}, (up_dn ? m_c == 15 : m_c == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] lb);
    rst = r; en = e; up_dn = u; load = l; load_bin = lb;
    prev_gray = gray;
    if (r) begin
      m_c = 0; m_s = 0; m_w = 0;
    end else if (l) begin
      m_c = int'(lb); m_s = 0; m_w = 0;
    end else if (e) begin
      m_s = 1;
      m_w = u ? (m_c == 15) : (m_c == 0);
      m_c = u ? (m_c + 1) % 16 : (m_c + 15) % 16;
    end else begin
      m_s = 0; m_w = 0;
    end
    @(posedge clk);
    #1;
    chk("gray", {28'd0, gray}, 32'(to_gray(m_c)));
    chk("step", {31'd0, step}, {31'd0, m_s});
    chk("wrap", {31'd0, wrap}, {31'd0, m_w});
    chk_tc("tc");
    if (m_s) chk("onebit", $countones(gray ^ prev_gray), 32'd1);
  endtask

  initial begin
    rst = 1; en = 1; up_dn = 1; load = 1; load_bin = 4'h7;
    cyc(1, 1, 1, 1, 4'h7);
    cyc(1, 1, 1, 1, 4'h7);
    chk("rst_gray", {28'd0, gray}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 1, 0, 4'h0);
      chk("up_seq", {28'd0, gray}, {28'd0, up_seq[i]});
      chk("up_wrap", {31'd0, wrap}, (i == 15) ? 32'd1 : 32'd0);
      chk("up_tc", {31'd0, tc}, (up_seq[i] == 4'h8) ? 32'd1 : 32'd0);
    end
    cyc(0, 0, 1, 1, 4'h8);
    chk("load8", {28'd0, gray}, 32'hC);
    cyc(0, 0, 1, 1, 4'hA);
    chk("loadA", {28'd0, gray}, 32'hF);
    cyc(0, 0, 1, 1, 4'h0);
    chk("load0", {28'd0, gray}, 32'h0);
    up_dn = 0;
    #1;
    chk("tc_dn0", {31'd0, tc}, 32'd1);
    up_dn = 1;
    #1;
    chk("tc_up0", {31'd0, tc}, 32'd0);
    cyc(0, 1, 0, 0, 4'h0);
    chk("dnwrap_gray", {28'd0, gray}, 32'h8);
    chk("dnwrap_wrap", {31'd0, wrap}, 32'd1);
    cyc(0, 1, 1, 1, 4'h5);
    chk("ld_en_gray", {28'd0, gray}, 32'h7);
    chk("ld_en_step", {31'd0, step}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 4'h0);
      chk("hold", {28'd0, gray}, 32'h7);
    end
    cyc(0, 0, 1, 1, 4'h0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 4'h0);
    chk("mid_D", {28'd0, gray}, 32'hD);
    cyc(1, 1, 1, 0, 4'h0);
    chk("mid_rst", {28'd0, gray}, 32'h0);
    cyc(0, 1, 1, 0, 4'h0);
    chk("post_rst", {28'd0, gray}, 32'h1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
          $urandom_range(0, 7) == 0, 4'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
